// File: rtl/rah_hash_packer_pkg.sv
// Shared RAH packer constants: header field positions, sync marker, payload word count, FSM states.
// The CRC state exists only when RAH_HASH_CHECKSUM_EN is defined.
package rah_hash_packer_pkg;

  localparam logic [7:0] RAH_SYNC_BYTE = 8'hA5;

  localparam int RAH_HDR_SYNC_MSB = 47;
  localparam int RAH_HDR_SYNC_LSB = 40;
  localparam int RAH_HDR_SEQ_MSB  = 39;
  localparam int RAH_HDR_SEQ_LSB  = 32;
  localparam int RAH_HDR_LEN_MSB  = 31;
  localparam int RAH_HDR_LEN_LSB  = 16;
  localparam int RAH_HDR_CNT_MSB  = 15;
  localparam int RAH_HDR_CNT_LSB  = 0;

  localparam int RAH_HASH_NWORDS = 6;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
`ifdef RAH_HASH_CHECKSUM_EN
    CRC,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/rah_hash_packer.sv
// Latches a 256-bit miner hash and writes it to the RAH encoder FIFO as a header plus MSB-first 48-bit words.
// Define RAH_HASH_CHECKSUM_EN to append an XOR checksum word after the payload.
module rah_hash_packer
  import rah_hash_packer_pkg::*;
#(
  parameter int         DATA_WIDTH = 48,
  parameter int         HASH_WIDTH = 256,
  parameter logic [7:0] SYNC_BYTE  = RAH_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hash_valid,
  input  logic [HASH_WIDTH-1:0] hash_data,
  output logic                  hash_ready,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [7:0]            seq_num,
  output logic                  busy
);

  localparam int NWORDS = (HASH_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PACK_W = NWORDS * DATA_WIDTH;

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [HASH_WIDTH-1:0]   hash_q;
  logic [7:0]              seq_q;
  logic [7:0]              next_seq;
  logic [PACK_W-1:0]       padded;
  logic [DATA_WIDTH-1:0]   word_sel;
  logic [DATA_WIDTH-1:0]   header;
  logic                    wr_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_d;
`ifdef RAH_HASH_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   acc_q;
`endif

  assign next_seq = seq_q + 8'd1;
  assign seq_num  = seq_q;

  always_comb begin
    header = '0;
    header[RAH_HDR_SYNC_MSB:RAH_HDR_SYNC_LSB] = SYNC_BYTE;
    header[RAH_HDR_SEQ_MSB:RAH_HDR_SEQ_LSB]   = next_seq;
    header[RAH_HDR_LEN_MSB:RAH_HDR_LEN_LSB]   = 16'(HASH_WIDTH);
    header[RAH_HDR_CNT_MSB:RAH_HDR_CNT_LSB]   = 16'(NWORDS);
  end

  // Hash is left-aligned in a whole number of words, so the last word is zero-padded in its LSBs.
  always_comb begin
    padded = '0;
    padded[PACK_W-1 -: HASH_WIDTH] = hash_q;
    word_sel = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (idx_q == 3'(k))
        word_sel = padded[PACK_W-1-k*DATA_WIDTH -: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:    if (hash_valid) state_d = HEADER;
      HEADER:  if (!fifo_full) begin
                 state_d = PAYLOAD;
                 idx_d   = '0;
               end
      PAYLOAD: if (!fifo_full) begin
                 if (idx_q == 3'(NWORDS - 1)) begin
`ifdef RAH_HASH_CHECKSUM_EN
                   state_d = CRC;
`else
                   state_d = DONE;
`endif
                 end else begin
                   idx_d = idx_q + 3'd1;
                 end
               end
`ifdef RAH_HASH_CHECKSUM_EN
      CRC:     if (!fifo_full) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hash_ready = (state_q == IDLE);
    busy       = 1'b0;
    wr_en_d    = 1'b0;
    wr_data_d  = '0;
    case (state_q)
      HEADER: begin
        busy      = 1'b1;
        wr_en_d   = !fifo_full;
        wr_data_d = header;
      end
      PAYLOAD: begin
        busy      = 1'b1;
        wr_en_d   = !fifo_full;
        wr_data_d = word_sel;
      end
`ifdef RAH_HASH_CHECKSUM_EN
      CRC: begin
        busy      = 1'b1;
        wr_en_d   = !fifo_full;
        wr_data_d = acc_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_q  <= '0;
      seq_q   <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
`ifdef RAH_HASH_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      wr_en <= wr_en_d;
      if (wr_en_d) wr_data <= wr_data_d;
      if (state_q == IDLE && hash_valid) hash_q <= hash_data;
      if (state_q == DONE) seq_q <= next_seq;
`ifdef RAH_HASH_CHECKSUM_EN
      // Header write restarts the accumulator, so the checksum never carries over between frames.
      if (wr_en_d) acc_q <= (state_q == HEADER) ? wr_data_d : (acc_q ^ wr_data_d);
`endif
    end
  end

endmodule

// File: tb/tb_rah_hash_packer.sv
// Scoreboard bench for rah_hash_packer: a frame model queues expected words, a monitor pops them on wr_en.
// Honours RAH_HASH_CHECKSUM_EN the same way as the design.
module tb_rah_hash_packer;

`ifdef RAH_HASH_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hash_valid;
  logic [255:0] hash_data;
  logic         hash_ready;
  logic         fifo_full;
  logic         wr_en;
  logic [47:0]  wr_data;
  logic [7:0]   seq_num;
  logic         busy;

  rah_hash_packer #(.DATA_WIDTH(48), .HASH_WIDTH(256), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .hash_valid(hash_valid), .hash_data(hash_data),
    .hash_ready(hash_ready), .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .seq_num(seq_num), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [47:0] data; bit is_hdr; bit is_last; } exp_t;
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hdr_cyc = 0;
  int          last_cyc = 0;
  logic [7:0]  last_hdr_seq = 8'h00;
  logic [7:0]  m_seq = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h expected none", wr_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_data", 64'(wr_data), 64'(e.data));
        if (e.is_hdr) begin
          hdr_cyc      = cyc;
          last_hdr_seq = wr_data[39:32];
        end
        if (e.is_last) last_cyc = cyc;
      end
    end
  end

  task automatic push_frame(input logic [255:0] h);
    logic [287:0] padded;
    logic [47:0]  w;
    logic [47:0]  x;
    padded = {h, 32'h0};
    m_seq  = m_seq + 8'd1;
    w = {8'hA5, m_seq, 16'd256, 16'd6};
    x = w;
    exp_q.push_back('{data: w, is_hdr: 1'b1, is_last: 1'b0});
    for (int k = 0; k < 6; k++) begin
      w = padded[287-48*k -: 48];
      x = x ^ w;
      exp_q.push_back('{data: w, is_hdr: 1'b0, is_last: (k == 5) && (EXTRA == 0)});
    end
    if (EXTRA == 1) exp_q.push_back('{data: x, is_hdr: 1'b0, is_last: 1'b1});
  endtask

  // Returns once the accepting edge has passed; n counts cycles spent waiting with hash_ready low.
  task automatic accept(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (hash_ready === 1'b1) break;
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
  endtask

  task automatic run_until_idle(input logic [31:0] pat, input bit rnd);
    int i;
    for (i = 0; i < 300; i++) begin
      if (rnd) fifo_full = ($urandom_range(0, 3) == 0);
      else     fifo_full = (i < 32) ? pat[i] : 1'b0;
      @(posedge clk); #1;
      if (hash_ready === 1'b1) break;
    end
    fifo_full = 1'b0;
    if (i >= 300) begin
      total++; bad++;
      $display("FAIL frame_timeout: got busy expected idle");
    end
  endtask

  task automatic send_frame(input logic [255:0] h, input logic [31:0] pat, input bit rnd);
    int n;
    hash_data  = h;
    hash_valid = 1'b1;
    accept(n);
    push_frame(h);
    hash_valid = 1'b0;
    run_until_idle(pat, rnd);
    chk("seq_num", 64'(seq_num), 64'(m_seq));
  endtask

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    m_seq = 8'h00;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; hash_valid = 1'b0; hash_data = '0; fifo_full = 1'b0;
    @(posedge clk); #1;
    chk("rst_hash_ready", 64'(hash_ready), 64'd1);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_seq_num", 64'(seq_num), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single frame, no back-pressure: header plus payload on consecutive cycles.
    send_frame({4{64'h0123456789ABCDEF}}, 32'h0, 1'b0);
    chk("hdr_seq_1", 64'(last_hdr_seq), 64'h01);
    chk("span_plain", 64'(last_cyc - hdr_cyc), 64'(6 + EXTRA));

    // Stall 3 cycles before word 2 and 1 cycle before word 5.
    send_frame(rand_hash(), 32'h0000_0238, 1'b0);
    chk("span_stalled", 64'(last_cyc - hdr_cyc), 64'(10 + EXTRA));

    // Back-to-back with hash_valid held: second hash waits for the first frame to finish.
    do_reset();
    hash_data  = rand_hash();
    hash_valid = 1'b1;
    accept(n);
    push_frame(hash_data);
    hash_data = rand_hash();
    accept(n);
    chk("b2b_ready_low_cycles", 64'(n), 64'(8 + EXTRA));
    chk("b2b_seq_between", 64'(seq_num), 64'h01);
    push_frame(hash_data);
    hash_valid = 1'b0;
    run_until_idle(32'h0, 1'b0);
    chk("b2b_hdr_seq", 64'(last_hdr_seq), 64'h02);
    chk("b2b_seq_num", 64'(seq_num), 64'h02);

    // Reset mid-frame after word 2 has been written.
    hash_data  = rand_hash();
    hash_valid = 1'b1;
    accept(n);
    push_frame(hash_data);
    hash_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("midrst_words_left", 64'(exp_q.size()), 64'(3 + EXTRA));
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_seq_num", 64'(seq_num), 64'd0);
    chk("midrst_hash_ready", 64'(hash_ready), 64'd1);
    exp_q.delete();
    m_seq = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(rand_hash(), 32'h0, 1'b1);
    chk("post_rst_hdr_seq", 64'(last_hdr_seq), 64'h01);

    // All-ones hash: exercises the padded last word and the checksum word when enabled.
    send_frame('1, 32'h0, 1'b0);
    chk("span_ones", 64'(last_cyc - hdr_cyc), 64'(6 + EXTRA));

    // Sequence wrap: 256 frames from reset with random back-pressure.
    do_reset();
    for (int f = 0; f < 256; f++) send_frame(rand_hash(), 32'h0, 1'b1);
    chk("wrap_hdr_seq", 64'(last_hdr_seq), 64'h00);
    chk("wrap_seq_num", 64'(seq_num), 64'h00);

    repeat (3) @(posedge clk);
    chk("leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
